// File: rtl/sobel_edge_packer.sv
// Thresholds sobel gradients into a 1-bit edge map, packs it LSB-first into
// row-aligned bytes, buffers them in a small FIFO and counts edges per frame.
module sobel_edge_packer #(
    parameter int OUT_W      = 62,
    parameter int OUT_H      = 62,
    parameter int GRAD_WIDTH = 11,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [GRAD_WIDTH-1:0]                gradient,
    input  logic                                 gradient_valid,
    input  logic [GRAD_WIDTH-1:0]                threshold,
    output logic [7:0]                           edge_byte,
    output logic                                 edge_valid,
    input  logic                                 edge_ready,
    output logic [$clog2(OUT_W*OUT_H+1)-1:0]     edge_count,
    output logic                                 frame_done,
    output logic                                 overflow
);

    localparam int CNT_W = $clog2(OUT_W*OUT_H+1);
    localparam int COL_W = $clog2(OUT_W);
    localparam int ROW_W = $clog2(OUT_H);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W-1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H-1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nxt;

    logic [GRAD_WIDTH-1:0] thr_q;
    logic [GRAD_WIDTH-1:0] thr_use;
    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [2:0]            bit_cnt;
    logic [7:0]            shreg;
    logic [7:0]            byte_cur;
    logic                  edge_bit;
    logic                  row_end;
    logic                  frame_end;
    logic                  byte_done;
    logic                  push;
    logic                  pop;
    logic                  full;
    logic [CNT_W-1:0]      run_cnt;
    logic [CNT_W-1:0]      run_cnt_nxt;
    logic [7:0]            mem [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr;
    logic [PTR_W:0]        rd_ptr;

    // The first pixel of a frame uses the live threshold; later ones the latch.
    always_comb begin
        thr_use     = (state == IDLE) ? threshold : thr_q;
        edge_bit    = (gradient >= thr_use);
        byte_cur    = shreg | (8'(edge_bit) << bit_cnt);
        row_end     = (col == COL_LAST);
        frame_end   = row_end && (row == ROW_LAST);
        byte_done   = (bit_cnt == 3'd7) || row_end;
        push        = gradient_valid && byte_done;
        edge_valid  = (wr_ptr != rd_ptr);
        pop         = edge_valid && edge_ready;
        full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
        edge_byte   = edge_valid ? mem[rd_ptr[PTR_W-1:0]] : 8'h00;
        run_cnt_nxt = run_cnt + CNT_W'(edge_bit);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (gradient_valid) state_nxt = RUN;
            RUN:  if (gradient_valid && frame_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            thr_q      <= '0;
            col        <= '0;
            row        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            run_cnt    <= '0;
            edge_count <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (gradient_valid) begin
                if (state == IDLE) thr_q <= threshold;
                if (byte_done) begin
                    shreg   <= '0;
                    bit_cnt <= '0;
                end else begin
                    shreg   <= byte_cur;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (row_end) begin
                    col <= '0;
                    row <= frame_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (frame_end) begin
                    edge_count <= run_cnt_nxt;
                    run_cnt    <= '0;
                    frame_done <= 1'b1;
                end else begin
                    run_cnt <= run_cnt_nxt;
                end
            end
        end
    end

    // A simultaneous pop frees the head slot, so a push into a full FIFO lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push && (!full || pop)) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && (!full || pop)) mem[wr_ptr[PTR_W-1:0]] <= byte_cur;
    end

endmodule
